// File: rtl/core_bus_pkg.sv
// Shared constants for the core datapath bus: widths, bus select codes and
// the bit positions of the increment request vector.
package core_bus_pkg;

  localparam int DATA_W = 16;
  localparam int REG_W  = 8;
  localparam int SEL_W  = 5;

  localparam logic [SEL_W-1:0] BUS_IM = 5'd0;
  localparam logic [SEL_W-1:0] BUS_DM = 5'd1;
  localparam logic [SEL_W-1:0] BUS_PC = 5'd2;
  localparam logic [SEL_W-1:0] BUS_DR = 5'd3;
  localparam logic [SEL_W-1:0] BUS_R  = 5'd4;
  localparam logic [SEL_W-1:0] BUS_AC = 5'd5;
  localparam logic [SEL_W-1:0] BUS_TR = 5'd6;
  localparam logic [SEL_W-1:0] BUS_R1 = 5'd7;
  localparam logic [SEL_W-1:0] BUS_R2 = 5'd8;
  localparam logic [SEL_W-1:0] BUS_RI = 5'd9;
  localparam logic [SEL_W-1:0] BUS_RJ = 5'd10;
  localparam logic [SEL_W-1:0] BUS_RK = 5'd11;
  localparam logic [SEL_W-1:0] BUS_R3 = 5'd12;
  localparam logic [SEL_W-1:0] BUS_RA = 5'd13;
  localparam logic [SEL_W-1:0] BUS_RB = 5'd14;
  localparam logic [SEL_W-1:0] BUS_RC = 5'd15;
  localparam logic [SEL_W-1:0] BUS_RX = 5'd16;
  localparam int               BUS_LAST = 16;

  localparam int INC_PC = 0;
  localparam int INC_RI = 1;
  localparam int INC_RJ = 2;
  localparam int INC_RK = 3;
  localparam int N_INC  = 4;

  // Counter registers, ordered by their inc_en bit.
  localparam logic [SEL_W-1:0] INC_CODE [N_INC] = '{BUS_PC, BUS_RI, BUS_RJ, BUS_RK};

  // Plain REG_W registers without increment; slot 0 must stay dr (memory address).
  localparam int N_PLAIN = 9;
  localparam logic [SEL_W-1:0] PLAIN_CODE [N_PLAIN] =
    '{BUS_DR, BUS_R, BUS_R1, BUS_R2, BUS_R3, BUS_RA, BUS_RB, BUS_RC, BUS_RX};

endpackage

// File: rtl/inc_reg.sv
// REG_W counter register: bus load wins over increment, increment wraps
// modulo 2^REG_W, asynchronous active-low clear.
module inc_reg
  import core_bus_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             inc,
  input  logic [REG_W-1:0] load_val,
  output logic [REG_W-1:0] q
);

  logic [REG_W-1:0] val_q, val_d;

  always_comb begin
    val_d = val_q;
    if (load) begin
      val_d = load_val;
    end else if (inc) begin
      val_d = val_q + REG_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      val_q <= '0;
    end else begin
      val_q <= val_d;
    end
  end

  assign q = val_q;

endmodule

// File: rtl/bus_write_bank.sv
// Destination side of the shared datapath bus: decodes write_en into one-hot
// load strobes and holds every architectural register the bus mux can read.
module bus_write_bank
  import core_bus_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [SEL_W-1:0]  write_en,
  input  logic [DATA_W-1:0] bus_in,
  input  logic [N_INC-1:0]  inc_en,
  input  logic              clr_ac,
  output logic              dm_we,
  output logic [REG_W-1:0]  dm_wdata,
  output logic [REG_W-1:0]  dm_addr,
  output logic [REG_W-1:0]  pc,
  output logic [REG_W-1:0]  dr,
  output logic [REG_W-1:0]  r,
  output logic [REG_W-1:0]  r1,
  output logic [REG_W-1:0]  r2,
  output logic [REG_W-1:0]  ri,
  output logic [REG_W-1:0]  rj,
  output logic [REG_W-1:0]  rk,
  output logic [REG_W-1:0]  r3,
  output logic [REG_W-1:0]  ra,
  output logic [REG_W-1:0]  rb,
  output logic [REG_W-1:0]  rc,
  output logic [REG_W-1:0]  rx,
  output logic [DATA_W-1:0] ac,
  output logic [DATA_W-1:0] tr
);

  // Codes 0 and 17-31 never match, so they write nothing.
  logic [BUS_LAST:1] we;

  always_comb begin
    we = '0;
    for (int i = 1; i <= BUS_LAST; i++) begin
      we[i] = (write_en == SEL_W'(i));
    end
  end

  logic [REG_W-1:0] plain_q [N_PLAIN];
  logic [REG_W-1:0] plain_d [N_PLAIN];

  always_comb begin
    for (int i = 0; i < N_PLAIN; i++) begin
      plain_d[i] = we[PLAIN_CODE[i]] ? bus_in[REG_W-1:0] : plain_q[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_PLAIN; i++) begin
        plain_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N_PLAIN; i++) begin
        plain_q[i] <= plain_d[i];
      end
    end
  end

  logic [DATA_W-1:0] ac_q, ac_d;
  logic [DATA_W-1:0] tr_q, tr_d;

  always_comb begin
    ac_d = ac_q;
    if (we[BUS_AC]) begin
      ac_d = bus_in;
    end else if (clr_ac) begin
      ac_d = '0;
    end
    tr_d = we[BUS_TR] ? bus_in : tr_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ac_q <= '0;
      tr_q <= '0;
    end else begin
      ac_q <= ac_d;
      tr_q <= tr_d;
    end
  end

  logic [REG_W-1:0] inc_q [N_INC];

  for (genvar gi = 0; gi < N_INC; gi++) begin : g_inc
    inc_reg u_inc_reg (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (we[INC_CODE[gi]]),
      .inc      (inc_en[gi]),
      .load_val (bus_in[REG_W-1:0]),
      .q        (inc_q[gi])
    );
  end

  // dm_addr is the registered dr, so a same-cycle dr write cannot move it.
  assign dm_we    = we[BUS_DM];
  assign dm_wdata = bus_in[REG_W-1:0];
  assign dm_addr  = plain_q[0];

  assign pc = inc_q[INC_PC];
  assign ri = inc_q[INC_RI];
  assign rj = inc_q[INC_RJ];
  assign rk = inc_q[INC_RK];

  assign dr = plain_q[0];
  assign r  = plain_q[1];
  assign r1 = plain_q[2];
  assign r2 = plain_q[3];
  assign r3 = plain_q[4];
  assign ra = plain_q[5];
  assign rb = plain_q[6];
  assign rc = plain_q[7];
  assign rx = plain_q[8];

  assign ac = ac_q;
  assign tr = tr_q;

endmodule

// File: tb/tb_bus_write_bank.sv
// Directed bench for bus_write_bank: a register model indexed by bus code is
// updated alongside each stimulus step and compared against every output.
module tb_bus_write_bank;

  logic        clk;
  logic        rst_n;
  logic [4:0]  write_en;
  logic [15:0] bus_in;
  logic [3:0]  inc_en;
  logic        clr_ac;
  logic        dm_we;
  logic [7:0]  dm_wdata, dm_addr;
  logic [7:0]  pc, dr, r, r1, r2, ri, rj, rk, r3, ra, rb, rc, rx;
  logic [15:0] ac, tr;

  int checks = 0;
  int errors = 0;

  logic [15:0] model [0:16];

  bus_write_bank dut (
    .clk(clk), .rst_n(rst_n), .write_en(write_en), .bus_in(bus_in),
    .inc_en(inc_en), .clr_ac(clr_ac), .dm_we(dm_we), .dm_wdata(dm_wdata),
    .dm_addr(dm_addr), .pc(pc), .dr(dr), .r(r), .r1(r1), .r2(r2), .ri(ri),
    .rj(rj), .rk(rk), .r3(r3), .ra(ra), .rb(rb), .rc(rc), .rx(rx),
    .ac(ac), .tr(tr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end else begin
      $display("ok   %s = %h", tag, got);
    end
  endtask

  function automatic logic [15:0] obs(input int c);
    case (c)
      2:  obs = {8'h00, pc};
      3:  obs = {8'h00, dr};
      4:  obs = {8'h00, r};
      5:  obs = ac;
      6:  obs = tr;
      7:  obs = {8'h00, r1};
      8:  obs = {8'h00, r2};
      9:  obs = {8'h00, ri};
      10: obs = {8'h00, rj};
      11: obs = {8'h00, rk};
      12: obs = {8'h00, r3};
      13: obs = {8'h00, ra};
      14: obs = {8'h00, rb};
      15: obs = {8'h00, rc};
      16: obs = {8'h00, rx};
      default: obs = 16'hxxxx;
    endcase
  endfunction

  task automatic check_all(input string tag);
    for (int c = 2; c <= 16; c++) begin
      check($sformatf("%s_reg%0d", tag, c), {16'h0, obs(c)}, {16'h0, model[c]});
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [4:0] code, input logic [15:0] data);
    write_en = code;
    bus_in   = data;
    step();
    if (code == 5'd5 || code == 5'd6) model[code] = data;
    else if (code >= 5'd2 && code <= 5'd16) model[code] = {8'h00, data[7:0]};
    write_en = 5'd0;
  endtask

  task automatic zero_model();
    for (int c = 0; c <= 16; c++) model[c] = 16'h0000;
  endtask

  initial begin
    zero_model();
    rst_n = 1'b0; write_en = 5'd2; bus_in = 16'h00AB; inc_en = 4'b0; clr_ac = 1'b0;
    step(); step(); step();
    check("rst_pc", {24'h0, pc}, 32'h0);
    check("rst_dm_we_low", {31'h0, dm_we}, 32'h0);
    check_all("rst");
    write_en = 5'd1; #1;
    check("rst_dm_we_follows", {31'h0, dm_we}, 32'h1);
    write_en = 5'd2; #1;
    rst_n = 1'b1;
    step();
    model[2] = 16'h00AB;
    write_en = 5'd0;
    check("release_pc", {24'h0, pc}, 32'hAB);

    wr(5'd3, 16'h12F0);
    check("trunc_dr", {24'h0, dr}, 32'hF0);
    wr(5'd5, 16'h12F0);
    check("full_ac", {16'h0, ac}, 32'h12F0);
    wr(5'd6, 16'hBEEF);
    check("full_tr", {16'h0, tr}, 32'hBEEF);

    wr(5'd2, 16'h00FF);
    inc_en = 4'b0001; step(); inc_en = 4'b0;
    model[2] = 16'h0000;
    check("pc_wrap", {24'h0, pc}, 32'h00);

    write_en = 5'd2; bus_in = 16'h0040; inc_en = 4'b0001;
    step();
    write_en = 5'd0; inc_en = 4'b0;
    model[2] = 16'h0040;
    check("pc_load_over_inc", {24'h0, pc}, 32'h40);

    wr(5'd9, 16'h0001); wr(5'd10, 16'h0002); wr(5'd11, 16'h0003);
    inc_en = 4'b1110;
    step(); step(); step();
    inc_en = 4'b0;
    model[9] = 16'h0004; model[10] = 16'h0005; model[11] = 16'h0006;
    check("par_ri", {24'h0, ri}, 32'h4);
    check("par_rj", {24'h0, rj}, 32'h5);
    check("par_rk", {24'h0, rk}, 32'h6);
    check("par_pc_hold", {24'h0, pc}, 32'h40);

    wr(5'd3, 16'h0020);
    write_en = 5'd1; bus_in = 16'h0077; #1;
    check("dm_we", {31'h0, dm_we}, 32'h1);
    check("dm_addr", {24'h0, dm_addr}, 32'h20);
    check("dm_wdata", {24'h0, dm_wdata}, 32'h77);
    step();
    write_en = 5'd0; #1;
    check("dm_we_off", {31'h0, dm_we}, 32'h0);
    check_all("dm");

    wr(5'd5, 16'h1234);
    write_en = 5'd5; bus_in = 16'h0009; clr_ac = 1'b1;
    step();
    write_en = 5'd0;
    model[5] = 16'h0009;
    check("ac_write_over_clr", {16'h0, ac}, 32'h0009);
    step();
    clr_ac = 1'b0;
    model[5] = 16'h0000;
    check("ac_clr", {16'h0, ac}, 32'h0000);

    wr(5'd4, 16'hFF11); wr(5'd7, 16'h0022); wr(5'd8, 16'h0033);
    wr(5'd12, 16'h0044); wr(5'd13, 16'h0055); wr(5'd14, 16'h0066);
    wr(5'd15, 16'h0011); wr(5'd15, 16'h0088); wr(5'd16, 16'h7799);
    check("b2b_rc", {24'h0, rc}, 32'h88);
    check_all("plain");

    write_en = 5'd0; bus_in = 16'hFFFF; #1;
    check("code0_dm_we", {31'h0, dm_we}, 32'h0);
    step();
    write_en = 5'd20; #1;
    check("code20_dm_we", {31'h0, dm_we}, 32'h0);
    step();
    write_en = 5'd31; step();
    write_en = 5'd0;
    check_all("illegal");

    write_en = 5'd2; bus_in = 16'h0055; inc_en = 4'b1111;
    rst_n = 1'b0; #1;
    zero_model();
    check("async_rst_pc", {24'h0, pc}, 32'h0);
    step();
    check_all("midrst");
    write_en = 5'd0; inc_en = 4'b0;
    rst_n = 1'b1;
    wr(5'd14, 16'h00C3);
    check("post_rst_rb", {24'h0, rb}, 32'hC3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
